// File: rtl/core_dbg_pkg.sv
// Shared types and constants for the debug run-control block:
// run states, debug register indices and CTRL/STATUS bit positions.
package core_dbg_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HALTING  = 2'd1,
        HALTED   = 2'd2,
        STEPPING = 2'd3
    } run_state_t;

    localparam logic [4:0] DBG_REG_CTRL   = 5'd0;
    localparam logic [4:0] DBG_REG_STATUS = 5'd1;
    localparam logic [4:0] DBG_REG_PC     = 5'd2;
    localparam logic [4:0] DBG_REG_STEP   = 5'd3;
    localparam int         DBG_SCRATCH_BASE = 4;

    localparam int CTRL_HALT_BIT    = 0;
    localparam int CTRL_RESUME_BIT  = 1;
    localparam int CTRL_STEP_BIT    = 2;
    localparam int CTRL_CLR_ERR_BIT = 3;

    localparam int STATUS_ERR_BIT     = 3;
    localparam int STATUS_PC_PEND_BIT = 4;

    localparam int STEP_CNT_WIDTH = 16;

    // A programmed step count of zero still executes one instruction.
    function automatic logic [STEP_CNT_WIDTH-1:0] step_target(input logic [STEP_CNT_WIDTH-1:0] cnt);
        return (cnt == 16'd0) ? 16'd1 : cnt;
    endfunction

endpackage

// File: rtl/core_dbg_regfile.sv
// Debug register space: storage, side-effect flags (ERR, PC_PEND),
// captured halt PC and the registered read port.
module core_dbg_regfile
    import core_dbg_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DBG_ADDR_WIDTH = 5,
    parameter int DBG_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dbg_req,
    input  logic                      dbg_wr_rd,
    input  logic [DBG_ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DBG_DATA_WIDTH-1:0] dbg_wdata,
    input  run_state_t                state,
    input  logic                      capture_en,
    input  logic [ADDR_WIDTH-3:0]     capture_pc,
    input  logic                      pc_pend_clr,
    output logic [DBG_DATA_WIDTH-1:0] dbg_rdata,
    output logic                      dbg_rd_ready,
    output logic [STEP_CNT_WIDTH-1:0] step_cnt,
    output logic                      pc_pend,
    output logic [ADDR_WIDTH-3:0]     pend_pc
);
    localparam int NUM_SCRATCH = (2 ** DBG_ADDR_WIDTH) - DBG_SCRATCH_BASE;

    logic [DBG_DATA_WIDTH-1:0] scratch_r [NUM_SCRATCH];
    logic [STEP_CNT_WIDTH-1:0] step_cnt_r;
    logic                      err_r;
    logic                      pc_pend_r;
    logic [ADDR_WIDTH-3:0]     pend_pc_r;
    logic [ADDR_WIDTH-3:0]     halt_pc_r;
    logic [DBG_DATA_WIDTH-1:0] rdata_r;
    logic                      rd_ready_r;
    logic [DBG_DATA_WIDTH-1:0] rd_word_s;
    logic [DBG_ADDR_WIDTH-1:0] scr_idx_s;
    logic                      wr_s;
    logic                      rd_s;

    assign wr_s      = dbg_req & dbg_wr_rd;
    assign rd_s      = dbg_req & ~dbg_wr_rd;
    assign scr_idx_s = dbg_addr - DBG_ADDR_WIDTH'(DBG_SCRATCH_BASE);

    // Register writes, halt-PC capture and pending-PC consumption
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_r[i] <= '0;
            end
            step_cnt_r <= 16'd1;
            err_r      <= 1'b0;
            pc_pend_r  <= 1'b0;
            pend_pc_r  <= '0;
            halt_pc_r  <= '0;
        end else begin
            if (capture_en) begin
                halt_pc_r <= capture_pc;
            end
            if (pc_pend_clr) begin
                pc_pend_r <= 1'b0;
            end
            if (wr_s) begin
                case (dbg_addr)
                    DBG_REG_CTRL: begin
                        if (dbg_wdata[CTRL_CLR_ERR_BIT]) begin
                            err_r <= 1'b0;
                        end
                    end
                    DBG_REG_STATUS: begin
                    end
                    // A PC override is only meaningful while fetch is parked.
                    DBG_REG_PC: begin
                        if (state == HALTED) begin
                            pend_pc_r <= dbg_wdata[ADDR_WIDTH-1:2];
                            pc_pend_r <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                    DBG_REG_STEP: begin
                        step_cnt_r <= dbg_wdata[STEP_CNT_WIDTH-1:0];
                    end
                    default: begin
                        scratch_r[scr_idx_s] <= dbg_wdata;
                    end
                endcase
            end
        end
    end

    // Read data selection
    always_comb begin
        rd_word_s = '0;
        case (dbg_addr)
            DBG_REG_CTRL: begin
                rd_word_s = '0;
            end
            DBG_REG_STATUS: begin
                rd_word_s[1:0]                = state;
                rd_word_s[STATUS_ERR_BIT]     = err_r;
                rd_word_s[STATUS_PC_PEND_BIT] = pc_pend_r;
            end
            DBG_REG_PC: begin
                rd_word_s = DBG_DATA_WIDTH'({halt_pc_r, 2'b00});
            end
            DBG_REG_STEP: begin
                rd_word_s = DBG_DATA_WIDTH'(step_cnt_r);
            end
            default: begin
                rd_word_s = scratch_r[scr_idx_s];
            end
        endcase
    end

    // Registered read response
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r    <= '0;
            rd_ready_r <= 1'b0;
        end else begin
            rd_ready_r <= rd_s;
            if (rd_s) begin
                rdata_r <= rd_word_s;
            end
        end
    end

    assign dbg_rdata    = rdata_r;
    assign dbg_rd_ready = rd_ready_r;
    assign step_cnt     = step_cnt_r;
    assign pc_pend      = pc_pend_r;
    assign pend_pc      = pend_pc_r;

endmodule

// File: rtl/core_run_ctrl.sv
// Debug run-control: halt / resume / N-step sequencing of the fetch stage,
// driving fetch_stall and a one-shot PC redirect.
module core_run_ctrl
    import core_dbg_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DBG_ADDR_WIDTH = 5,
    parameter int DBG_DATA_WIDTH = 32,
    parameter bit RST_HALTED     = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dbg_req,
    input  logic                      dbg_wr_rd,
    input  logic [DBG_ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DBG_DATA_WIDTH-1:0] dbg_wdata,
    output logic [DBG_DATA_WIDTH-1:0] dbg_rdata,
    output logic                      dbg_rd_ready,
    input  logic [ADDR_WIDTH-3:0]     fetch_pc,
    input  logic                      fetch_valid,
    input  logic                      fetch_busy,
    output logic                      fetch_stall,
    output logic                      pc_load,
    output logic [ADDR_WIDTH-3:0]     pc_load_addr,
    output logic                      core_halted
);
    localparam run_state_t RESET_STATE = RST_HALTED ? HALTED : RUN;

    run_state_t                state_r;
    run_state_t                state_next_s;
    logic [STEP_CNT_WIDTH-1:0] step_done_r;
    logic [STEP_CNT_WIDTH-1:0] step_inc_s;
    logic [STEP_CNT_WIDTH-1:0] step_cnt_s;
    logic                      step_reached_s;
    logic                      ctrl_wr_s;
    logic                      halt_cmd_s;
    logic                      resume_cmd_s;
    logic                      step_cmd_s;
    logic                      pc_pend_s;
    logic [ADDR_WIDTH-3:0]     pend_pc_s;
    logic                      capture_en_s;
    logic                      leave_halted_s;
    logic                      stall_next_s;
    logic                      halted_next_s;
    logic                      load_next_s;
    logic                      fetch_stall_r;
    logic                      core_halted_r;
    logic                      pc_load_r;
    logic [ADDR_WIDTH-3:0]     pc_load_addr_r;

    assign ctrl_wr_s    = dbg_req & dbg_wr_rd & (dbg_addr == DBG_REG_CTRL);
    assign halt_cmd_s   = ctrl_wr_s & dbg_wdata[CTRL_HALT_BIT];
    assign resume_cmd_s = ctrl_wr_s & dbg_wdata[CTRL_RESUME_BIT];
    assign step_cmd_s   = ctrl_wr_s & dbg_wdata[CTRL_STEP_BIT];

    assign step_inc_s     = (step_done_r == 16'hFFFF) ? step_done_r : (step_done_r + 16'd1);
    assign step_reached_s = fetch_valid & (step_inc_s >= step_target(step_cnt_s));
    assign capture_en_s   = (state_r == HALTING) & ~fetch_busy;

    core_dbg_regfile #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DBG_ADDR_WIDTH (DBG_ADDR_WIDTH),
        .DBG_DATA_WIDTH (DBG_DATA_WIDTH)
    ) u_regfile (
        .clk          (clk),
        .rst          (rst),
        .dbg_req      (dbg_req),
        .dbg_wr_rd    (dbg_wr_rd),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .state        (state_r),
        .capture_en   (capture_en_s),
        .capture_pc   (fetch_pc),
        .pc_pend_clr  (leave_halted_s),
        .dbg_rdata    (dbg_rdata),
        .dbg_rd_ready (dbg_rd_ready),
        .step_cnt     (step_cnt_s),
        .pc_pend      (pc_pend_s),
        .pend_pc      (pend_pc_s)
    );

    // State register and step progress counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RESET_STATE;
            step_done_r <= '0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == HALTED) && (state_next_s == STEPPING)) begin
                step_done_r <= '0;
            end else if ((state_r == STEPPING) && fetch_valid) begin
                step_done_r <= step_inc_s;
            end
        end
    end

    // Next-state logic; case order encodes HALT > RESUME > STEP among legal commands
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (halt_cmd_s) state_next_s = HALTING;
                else            state_next_s = RUN;
            end
            HALTING: begin
                if (!fetch_busy) state_next_s = HALTED;
                else             state_next_s = HALTING;
            end
            HALTED: begin
                if (resume_cmd_s)    state_next_s = RUN;
                else if (step_cmd_s) state_next_s = STEPPING;
                else                 state_next_s = HALTED;
            end
            STEPPING: begin
                if (halt_cmd_s || step_reached_s) state_next_s = HALTING;
                else                              state_next_s = STEPPING;
            end
            default: begin
                state_next_s = RESET_STATE;
            end
        endcase
    end

    // Output decode from the upcoming state so registered outputs track state_r
    always_comb begin
        stall_next_s   = (state_next_s == HALTING) || (state_next_s == HALTED);
        halted_next_s  = (state_next_s == HALTED);
        leave_halted_s = (state_r == HALTED) && (state_next_s != HALTED);
        load_next_s    = leave_halted_s && pc_pend_s;
    end

    // Registered fetch-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_stall_r  <= RST_HALTED;
            core_halted_r  <= RST_HALTED;
            pc_load_r      <= 1'b0;
            pc_load_addr_r <= '0;
        end else begin
            fetch_stall_r <= stall_next_s;
            core_halted_r <= halted_next_s;
            pc_load_r     <= load_next_s;
            if (load_next_s) begin
                pc_load_addr_r <= pend_pc_s;
            end
        end
    end

    assign fetch_stall  = fetch_stall_r;
    assign core_halted  = core_halted_r;
    assign pc_load      = pc_load_r;
    assign pc_load_addr = pc_load_addr_r;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: register table, read scoreboard,
// and hand-written halt / resume / step / reset sequences.
module tb_core_run_ctrl;
    import core_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_req;
    logic        dbg_wr_rd;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;
    logic        dbg_rd_ready;
    logic [29:0] fetch_pc;
    logic        fetch_valid;
    logic        fetch_busy;
    logic        fetch_stall;
    logic        pc_load;
    logic [29:0] pc_load_addr;
    logic        core_halted;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];
    logic        rd_exp = 1'b0;
    int          load_cnt = 0;
    logic [29:0] load_addr = '0;
    logic        load_stall = 1'b0;
    logic        load_prev_stall = 1'b0;
    logic        prev_stall = 1'b0;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [12];

    core_run_ctrl #(
        .ADDR_WIDTH     (32),
        .DBG_ADDR_WIDTH (5),
        .DBG_DATA_WIDTH (32),
        .RST_HALTED     (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dbg_req      (dbg_req),
        .dbg_wr_rd    (dbg_wr_rd),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_rdata    (dbg_rdata),
        .dbg_rd_ready (dbg_rd_ready),
        .fetch_pc     (fetch_pc),
        .fetch_valid  (fetch_valid),
        .fetch_busy   (fetch_busy),
        .fetch_stall  (fetch_stall),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .core_halted  (core_halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
        dbg_req   = 1'b1;
        dbg_wr_rd = 1'b1;
        dbg_addr  = a;
        dbg_wdata = d;
        tick();
        dbg_req   = 1'b0;
        dbg_wr_rd = 1'b0;
    endtask

    task automatic dbg_read(input logic [4:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        dbg_req   = 1'b1;
        dbg_wr_rd = 1'b0;
        dbg_addr  = a;
        tick();
        dbg_req   = 1'b0;
    endtask

    // Remember whether a read was accepted on this edge
    always @(posedge clk) begin
        rd_exp <= dbg_req && !dbg_wr_rd && !rst;
    end

    // Read scoreboard and pc_load observation
    always @(negedge clk) begin
        if (rd_exp || (dbg_rd_ready === 1'b1)) begin
            check("rd_ready_timing", {31'd0, dbg_rd_ready}, {31'd0, rd_exp});
        end
        if (dbg_rd_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rdata_unexpected", 32'd1, 32'd0);
            end else begin
                check("rdata", dbg_rdata, exp_q.pop_front());
            end
        end
        if (pc_load === 1'b1) begin
            load_cnt++;
            load_addr       = pc_load_addr;
            load_stall      = fetch_stall;
            load_prev_stall = prev_stall;
        end
        prev_stall = fetch_stall;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        vecs[0]  = '{wr: 1'b1, addr: 5'd4,           data: 32'h12345678, exp: 32'h0};
        vecs[1]  = '{wr: 1'b0, addr: 5'd4,           data: 32'h0,        exp: 32'h12345678};
        vecs[2]  = '{wr: 1'b1, addr: 5'd31,          data: 32'hDEADBEEF, exp: 32'h0};
        vecs[3]  = '{wr: 1'b0, addr: 5'd31,          data: 32'h0,        exp: 32'hDEADBEEF};
        vecs[4]  = '{wr: 1'b1, addr: DBG_REG_STEP,   data: 32'hABCD1234, exp: 32'h0};
        vecs[5]  = '{wr: 1'b0, addr: DBG_REG_STEP,   data: 32'h0,        exp: 32'h00001234};
        vecs[6]  = '{wr: 1'b0, addr: DBG_REG_CTRL,   data: 32'h0,        exp: 32'h0};
        vecs[7]  = '{wr: 1'b1, addr: DBG_REG_STATUS, data: 32'hFFFFFFFF, exp: 32'h0};
        vecs[8]  = '{wr: 1'b0, addr: DBG_REG_STATUS, data: 32'h0,        exp: 32'h0};
        vecs[9]  = '{wr: 1'b1, addr: DBG_REG_STEP,   data: 32'h1,        exp: 32'h0};
        vecs[10] = '{wr: 1'b0, addr: DBG_REG_STEP,   data: 32'h0,        exp: 32'h1};
        vecs[11] = '{wr: 1'b0, addr: 5'd17,          data: 32'h0,        exp: 32'h0};

        rst = 1'b1; dbg_req = 1'b0; dbg_wr_rd = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
        fetch_pc = 30'd0; fetch_valid = 1'b0; fetch_busy = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(10);
        check("rst_fetch_stall", {31'd0, fetch_stall}, 32'd0);
        check("rst_core_halted", {31'd0, core_halted}, 32'd0);
        check("rst_pc_load", {31'd0, pc_load}, 32'd0);
        dbg_read(DBG_REG_STATUS, 32'h0);
        dbg_read(DBG_REG_STEP, 32'h1);
        idle(2);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) dbg_write(vecs[i].addr, vecs[i].data);
            else            dbg_read(vecs[i].addr, vecs[i].exp);
        end
        idle(2);

        // Halt while fetch is still busy
        fetch_busy = 1'b1;
        fetch_pc   = 30'h100;
        dbg_write(DBG_REG_CTRL, 32'h1);
        dbg_read(DBG_REG_STATUS, 32'h1);
        tick();
        check("halting_stall", {31'd0, fetch_stall}, 32'd1);
        check("halting_not_halted", {31'd0, core_halted}, 32'd0);
        fetch_busy = 1'b0;
        idle(2);
        check("halted_flag", {31'd0, core_halted}, 32'd1);
        check("halted_stall", {31'd0, fetch_stall}, 32'd1);
        dbg_read(DBG_REG_STATUS, 32'h2);
        dbg_read(DBG_REG_PC, 32'h400);
        idle(2);

        // PC override then resume
        dbg_write(DBG_REG_PC, 32'h2000);
        dbg_read(DBG_REG_STATUS, 32'h12);
        base = load_cnt;
        dbg_write(DBG_REG_CTRL, 32'h2);
        check("resume_pc_load", {31'd0, pc_load}, 32'd1);
        check("resume_load_addr", {2'd0, pc_load_addr}, 32'h800);
        check("resume_stall_low", {31'd0, fetch_stall}, 32'd0);
        tick();
        check("resume_pc_load_oneshot", {31'd0, pc_load}, 32'd0);
        idle(3);
        check("resume_load_count", load_cnt - base, 32'd1);
        check("resume_prev_stall", {31'd0, load_prev_stall}, 32'd1);
        check("resume_stall_at_load", {31'd0, load_stall}, 32'd0);
        check("resume_load_addr_mon", {2'd0, load_addr}, 32'h800);
        dbg_read(DBG_REG_STATUS, 32'h0);
        idle(2);

        // Three-instruction step
        dbg_write(DBG_REG_CTRL, 32'h1);
        idle(2);
        check("step_pre_halted", {31'd0, core_halted}, 32'd1);
        dbg_write(DBG_REG_STEP, 32'h3);
        dbg_write(DBG_REG_CTRL, 32'h4);
        check("step_stall_low", {31'd0, fetch_stall}, 32'd0);
        check("step_not_halted", {31'd0, core_halted}, 32'd0);
        fetch_pc = 30'h200;
        for (int k = 0; k < 3; k++) begin
            fetch_valid = 1'b1;
            tick();
            fetch_valid = 1'b0;
            if (k < 2) check("step_still_running", {31'd0, fetch_stall}, 32'd0);
            else       check("step_stall_after_last", {31'd0, fetch_stall}, 32'd1);
            tick();
        end
        check("step_halted", {31'd0, core_halted}, 32'd1);
        dbg_read(DBG_REG_STATUS, 32'h2);
        dbg_read(DBG_REG_PC, 32'h800);
        idle(2);

        // Step count of zero behaves as one
        dbg_write(DBG_REG_STEP, 32'h0);
        dbg_write(DBG_REG_CTRL, 32'h4);
        check("step0_stall_low", {31'd0, fetch_stall}, 32'd0);
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        check("step0_stall_after_one", {31'd0, fetch_stall}, 32'd1);
        tick();
        check("step0_halted", {31'd0, core_halted}, 32'd1);
        check("step_no_extra_load", load_cnt - base, 32'd1);

        // PC write outside HALTED sets ERR and never redirects
        dbg_write(DBG_REG_CTRL, 32'h2);
        dbg_write(DBG_REG_PC, 32'h40);
        dbg_read(DBG_REG_STATUS, 32'h8);
        idle(3);
        check("err_no_load", load_cnt - base, 32'd1);
        dbg_write(DBG_REG_CTRL, 32'h8);
        dbg_read(DBG_REG_STATUS, 32'h0);
        idle(2);

        // All three command bits while HALTED: RESUME wins
        dbg_write(DBG_REG_CTRL, 32'h1);
        idle(2);
        dbg_write(DBG_REG_CTRL, 32'h7);
        check("prio_not_halted", {31'd0, core_halted}, 32'd0);
        check("prio_stall_low", {31'd0, fetch_stall}, 32'd0);
        dbg_read(DBG_REG_STATUS, 32'h0);
        idle(2);

        // Reset while stepping
        dbg_write(DBG_REG_CTRL, 32'h1);
        idle(2);
        dbg_write(DBG_REG_STEP, 32'h5);
        dbg_write(DBG_REG_CTRL, 32'h4);
        dbg_read(DBG_REG_STATUS, 32'h3);
        idle(2);
        base = load_cnt;
        rst = 1'b1;
        tick();
        check("rst_step_stall", {31'd0, fetch_stall}, 32'd0);
        check("rst_step_halted", {31'd0, core_halted}, 32'd0);
        check("rst_step_pc_load", {31'd0, pc_load}, 32'd0);
        rst = 1'b0;
        idle(2);
        dbg_read(DBG_REG_STATUS, 32'h0);
        dbg_read(DBG_REG_STEP, 32'h1);
        dbg_read(5'd31, 32'h0);
        idle(3);
        check("rst_step_no_load", load_cnt - base, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
